ex_alu_stage: RTL and testbench

- Execute stage directly downstream of the ALU control decoder.
- Consumes the 4-bit alu_control code, the two operands and the forwarded MEM/WB control bits, and computes the ALU result and zero flag.
- Results are buffered in a 2-entry skid buffer that forms the EX/MEM pipeline boundary.
- Valid/ready handshakes on both sides; synchronous flush for branch mispredict/redirect.

---
 rtl/ex_alu_stage.sv | 144 ++++++++++++++
 tb/tb_ex_alu_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - execute-stage ALU with 2-entry skid buffer at the EX/MEM boundary
module ex_alu_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            alu_control,
   input  logic [XLEN-1:0]       operand_a,
   input  logic [XLEN-1:0]       operand_b,
   input  logic [XLEN-1:0]       store_data,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic                  reg_write_in,
   input  logic                  mem_read_in,
   input  logic                  mem_write_in,
   input  logic                  branch_in,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       alu_result,
   output logic                  zero,
   output logic                  branch_taken,
   output logic                  illegal_op,
   output logic [XLEN-1:0]       store_data_out,
   output logic [REG_ADDR_W-1:0] rd_out,
   output logic                  reg_write_out,
   output logic                  mem_read_out,
   output logic                  mem_write_out
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;

   typedef struct packed {
      logic [XLEN-1:0]       result;
      logic                  zero;
      logic                  branch_taken;
      logic                  illegal;
      logic [XLEN-1:0]       store_data;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
   } entry_t;

   entry_t     new_entry;
   entry_t     head_q, head_d;
   entry_t     skid_q, skid_d;
   logic [1:0] state_q, state_d;
   logic       in_ready_q;
   logic       acc_fire;
   logic       rel_fire;

   // Unsupported codes produce a harmless entry: result 0, no register or memory write.
   always_comb begin
      new_entry = '0;
      case (alu_control)
         OP_AND:  new_entry.result = operand_a & operand_b;
         OP_OR:   new_entry.result = operand_a | operand_b;
         OP_ADD:  new_entry.result = operand_a + operand_b;
         OP_SUB:  new_entry.result = operand_a - operand_b;
         default: new_entry.illegal = 1'b1;
      endcase
      new_entry.zero         = (new_entry.result == '0);
      new_entry.branch_taken = branch_in & new_entry.zero;
      new_entry.store_data   = store_data;
      new_entry.rd           = rd_in;
      new_entry.reg_write    = reg_write_in & ~new_entry.illegal;
      new_entry.mem_read     = mem_read_in;
      new_entry.mem_write    = mem_write_in & ~new_entry.illegal;
   end

   assign acc_fire = in_valid & in_ready_q & ~flush;
   assign rel_fire = (state_q != ST_EMPTY) & out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (acc_fire) begin
               head_d  = new_entry;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (acc_fire && rel_fire) begin
               head_d = new_entry;
            end else if (acc_fire) begin
               skid_d  = new_entry;
               state_d = ST_TWO;
            end else if (rel_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (rel_fire) begin
               head_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         head_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_TWO);
         head_q     <= head_d;
         skid_q     <= skid_d;
      end
   end

   assign in_ready       = in_ready_q;
   assign out_valid      = (state_q != ST_EMPTY);
   assign alu_result     = head_q.result;
   assign zero           = head_q.zero;
   assign branch_taken   = head_q.branch_taken;
   assign illegal_op     = head_q.illegal;
   assign store_data_out = head_q.store_data;
   assign rd_out         = head_q.rd;
   assign reg_write_out  = head_q.reg_write;
   assign mem_read_out   = head_q.mem_read;
   assign mem_write_out  = head_q.mem_write;

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - directed self-checking bench for ex_alu_stage
module tb_ex_alu_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_control;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [31:0] store_data;
   logic [4:0]  rd_in;
   logic        reg_write_in;
   logic        mem_read_in;
   logic        mem_write_in;
   logic        branch_in;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_result;
   logic        zero;
   logic        branch_taken;
   logic        illegal_op;
   logic [31:0] store_data_out;
   logic [4:0]  rd_out;
   logic        reg_write_out;
   logic        mem_read_out;
   logic        mem_write_out;

   int checks = 0;
   int fails  = 0;

   ex_alu_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .alu_control    (alu_control),
      .operand_a      (operand_a),
      .operand_b      (operand_b),
      .store_data     (store_data),
      .rd_in          (rd_in),
      .reg_write_in   (reg_write_in),
      .mem_read_in    (mem_read_in),
      .mem_write_in   (mem_write_in),
      .branch_in      (branch_in),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .alu_result     (alu_result),
      .zero           (zero),
      .branch_taken   (branch_taken),
      .illegal_op     (illegal_op),
      .store_data_out (store_data_out),
      .rd_out         (rd_out),
      .reg_write_out  (reg_write_out),
      .mem_read_out   (mem_read_out),
      .mem_write_out  (mem_write_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      in_valid    = v;
      alu_control = op;
      operand_a   = a;
      operand_b   = b;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      store_data = 32'h0; rd_in = 5'd0;
      reg_write_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; branch_in = 1'b0;
      step();
      step();
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result", alu_result, 32'd0);
      chk("rst_flags", {29'b0, zero, branch_taken, illegal_op}, 32'd0);
      rst_n = 1'b1;

      // single ADD with pass-through fields
      out_ready = 1'b1;
      drive(1'b1, 4'b0010, 32'd5, 32'd7);
      store_data = 32'hDEAD_BEEF; rd_in = 5'd3; reg_write_in = 1'b1; mem_read_in = 1'b1;
      step();
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      chk("add_valid", {31'b0, out_valid}, 32'd1);
      chk("add_result", alu_result, 32'd12);
      chk("add_zero", {31'b0, zero}, 32'd0);
      chk("add_store_data", store_data_out, 32'hDEAD_BEEF);
      chk("add_ctrl", {24'b0, rd_out, reg_write_out, mem_read_out, mem_write_out}, {24'b0, 5'd3, 3'b110});
      step();
      chk("add_drained", {31'b0, out_valid}, 32'd0);

      // SUB to zero with branch, then SUB wrap-around back-to-back
      mem_read_in = 1'b0;
      drive(1'b1, 4'b0110, 32'h1234, 32'h1234);
      branch_in = 1'b1;
      step();
      chk("sub0_result", alu_result, 32'd0);
      chk("sub0_zero_br", {30'b0, zero, branch_taken}, 32'd3);
      drive(1'b1, 4'b0110, 32'd0, 32'd1);
      branch_in = 1'b0;
      step();
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      chk("subwrap_result", alu_result, 32'hFFFF_FFFF);
      chk("subwrap_zero_br", {30'b0, zero, branch_taken}, 32'd0);
      step();
      chk("sub_drained", {31'b0, out_valid}, 32'd0);

      // backpressure: fill both entries, third offer must wait
      out_ready = 1'b0;
      drive(1'b1, 4'b0000, 32'h0000_F0F0, 32'h0000_0FF0);
      step();
      chk("bp1_in_ready", {31'b0, in_ready}, 32'd1);
      chk("bp1_head", alu_result, 32'h0000_00F0);
      drive(1'b1, 4'b0001, 32'h0000_F0F0, 32'h0000_0FF0);
      step();
      chk("bp2_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp2_head", alu_result, 32'h0000_00F0);
      drive(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1);
      step();
      chk("bp3_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp3_head", alu_result, 32'h0000_00F0);
      step();
      chk("bp4_head_stable", alu_result, 32'h0000_00F0);
      chk("bp4_valid", {31'b0, out_valid}, 32'd1);
      out_ready = 1'b1;
      step();
      chk("bp5_head", alu_result, 32'h0000_FFF0);
      chk("bp5_in_ready", {31'b0, in_ready}, 32'd1);
      step();
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      chk("bp6_head", alu_result, 32'd0);
      chk("bp6_zero", {31'b0, zero}, 32'd1);
      chk("bp6_valid", {31'b0, out_valid}, 32'd1);
      step();
      chk("bp_drained", {31'b0, out_valid}, 32'd0);

      // streaming: one result per cycle, in_ready stays high
      drive(1'b1, 4'b0010, 32'd0, 32'd100);
      step();
      for (int i = 1; i < 6; i++) begin
         chk("stream_result", alu_result, 32'd100 + 32'(i - 1));
         chk("stream_ready", {30'b0, out_valid, in_ready}, 32'd3);
         drive(1'b1, 4'b0010, 32'(i), 32'd100);
         step();
      end
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      chk("stream_last", alu_result, 32'd105);
      step();
      chk("stream_drained", {31'b0, out_valid}, 32'd0);

      // flush while TWO is full with a fresh offer
      out_ready = 1'b0;
      drive(1'b1, 4'b0010, 32'd1, 32'd1);
      step();
      drive(1'b1, 4'b0010, 32'd2, 32'd2);
      step();
      chk("fl_full", {30'b0, out_valid, in_ready}, 32'd2);
      drive(1'b1, 4'b0010, 32'd8, 32'd8);
      flush = 1'b1;
      step();
      chk("fl_after", {30'b0, out_valid, in_ready}, 32'd1);
      flush = 1'b0;
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      out_ready = 1'b1;
      step();
      chk("fl_nothing", {31'b0, out_valid}, 32'd0);
      // offer during flush from EMPTY must also be dropped
      drive(1'b1, 4'b0010, 32'd9, 32'd9);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      chk("fl_empty_offer", {30'b0, out_valid, in_ready}, 32'd1);

      // illegal opcode, then reset while TWO
      out_ready = 1'b0;
      reg_write_in = 1'b1; mem_write_in = 1'b1; rd_in = 5'd7; store_data = 32'h55;
      drive(1'b1, 4'b0101, 32'd3, 32'd4);
      step();
      chk("ill_flag", {31'b0, illegal_op}, 32'd1);
      chk("ill_result", alu_result, 32'd0);
      chk("ill_writes", {30'b0, reg_write_out, mem_write_out}, 32'd0);
      mem_write_in = 1'b0;
      drive(1'b1, 4'b0010, 32'd1, 32'd2);
      step();
      chk("ill_two", {30'b0, out_valid, in_ready}, 32'd2);
      rst_n = 1'b0;
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      step();
      chk("rst2_hs", {30'b0, out_valid, in_ready}, 32'd1);
      chk("rst2_result", alu_result, 32'd0);
      chk("rst2_flags", {29'b0, zero, branch_taken, illegal_op}, 32'd0);
      chk("rst2_pass", store_data_out | {24'b0, rd_out, reg_write_out, mem_read_out, mem_write_out}, 32'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      chk("rst2_discarded", {31'b0, out_valid}, 32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
